// File: rtl/ines_pkg.sv
// iNES loader shared definitions.
// States, header constants and mapper_flags layout.
package ines_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_TRAINER,
        S_PRG,
        S_CHR,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [21:0] CHR_BASE_DEFAULT      = 22'h200000;
    localparam int          MAX_PRG_BANKS_DEFAULT = 128;

    localparam int PRG_SHIFT = 14;
    localparam int CHR_SHIFT = 13;

    localparam logic [21:0] HDR_LAST    = 22'd15;
    localparam logic [21:0] TRAINER_LEN = 22'd512;

    localparam logic [7:0] MAGIC0 = 8'h4E;
    localparam logic [7:0] MAGIC1 = 8'h45;
    localparam logic [7:0] MAGIC2 = 8'h53;
    localparam logic [7:0] MAGIC3 = 8'h1A;

    localparam int MF_PRG_LSB  = 8;
    localparam int MF_CHR_LSB  = 16;
    localparam int MF_MIRROR   = 24;
    localparam int MF_BATTERY  = 25;
    localparam int MF_FOUR_SCR = 26;
    localparam int MF_CHR_RAM  = 27;

    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        logic [7:0] m;
        m = MAGIC0;
        unique case (idx)
            2'd0: m = MAGIC0;
            2'd1: m = MAGIC1;
            2'd2: m = MAGIC2;
            2'd3: m = MAGIC3;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] build_flags(
        input logic [7:0] prg,
        input logic [7:0] chr,
        input logic [7:0] f6,
        input logic [3:0] f7hi
    );
        logic [31:0] f;
        f = '0;
        f[7:0] = {f7hi, f6[7:4]};
        f[MF_PRG_LSB +: 8] = prg;
        f[MF_CHR_LSB +: 8] = chr;
        f[MF_MIRROR]   = f6[0];
        f[MF_BATTERY]  = f6[1];
        f[MF_FOUR_SCR] = f6[3];
        f[MF_CHR_RAM]  = (chr == 8'd0);
        return f;
    endfunction

endpackage

// File: rtl/ines_wr_buffer.sv
// Single-entry write holding register.
// Holds one addr/data pair until the memory acks it.
module ines_wr_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        load,
    input  logic [21:0] addr,
    input  logic [7:0]  data,
    input  logic        ack,
    output logic [21:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_write,
    output logic        ready,
    output logic        overflow
);

    // Empty, or emptying this cycle.
    assign ready = !mem_write || ack;

    // A new byte with the entry still held and no ack would be lost.
    assign overflow = load && mem_write && !ack;

    // Entry register: clear wins, load replaces, ack empties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_data  <= '0;
            mem_write <= 1'b0;
        end else if (clr) begin
            mem_write <= 1'b0;
        end else if (load) begin
            mem_addr  <= addr;
            mem_data  <= data;
            mem_write <= 1'b1;
        end else if (ack) begin
            mem_write <= 1'b0;
        end
    end

endmodule

// File: rtl/ines_loader.sv
// iNES stream loader: header check, trainer skip,
// PRG/CHR writes and mapper configuration decode.
module ines_loader
    import ines_pkg::*;
#(
    parameter logic [21:0] CHR_BASE      = CHR_BASE_DEFAULT,
    parameter int          MAX_PRG_BANKS = MAX_PRG_BANKS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        downloading,
    input  logic [7:0]  indata,
    input  logic        indata_clk,
    output logic [21:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_write,
    input  logic        mem_ack,
    output logic [31:0] mapper_flags,
    output logic        done,
    output logic        error
);

    localparam logic [8:0] MAX_PRG = 9'(MAX_PRG_BANKS);

    state_t      state, state_n;
    logic [21:0] cnt, cnt_n;
    logic [7:0]  prg_banks;
    logic [7:0]  chr_banks;
    logic [7:0]  flags6;
    logic [3:0]  flags7_hi;
    logic        dl_q;

    logic        dl_rise;
    logic [21:0] prg_size;
    logic [21:0] chr_size;
    logic        prg_full;
    logic        chr_full;
    logic        hdr_bad;
    logic        hdr_strobe;
    logic        hdr_start;
    logic        load;
    logic [21:0] wr_addr;
    logic        wb_clr;
    logic        wb_ready;
    logic        wb_ovf;

    assign dl_rise  = downloading && !dl_q;
    assign prg_size = {14'd0, prg_banks} << PRG_SHIFT;
    assign chr_size = {14'd0, chr_banks} << CHR_SHIFT;
    assign prg_full = (cnt == prg_size);
    assign chr_full = (cnt == chr_size);
    assign hdr_bad  = (prg_banks == 8'd0) ||
                      ({1'b0, prg_banks} > MAX_PRG);

    assign hdr_strobe = (state == S_HEADER) && indata_clk && downloading;
    assign hdr_start  = (state_n == S_HEADER) && (state != S_HEADER);

    assign load = indata_clk && downloading &&
                  (((state == S_PRG) && !prg_full) ||
                   ((state == S_CHR) && !chr_full));

    assign wr_addr = (state == S_CHR) ? CHR_BASE + cnt : cnt;
    assign wb_clr  = (state_n == S_ERROR);

    assign done  = (state == S_DONE);
    assign error = (state == S_ERROR);

    ines_wr_buffer u_wb (
        .clk       (clk),
        .reset     (reset),
        .clr       (wb_clr),
        .load      (load),
        .addr      (wr_addr),
        .data      (indata),
        .ack       (mem_ack),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_write (mem_write),
        .ready     (wb_ready),
        .overflow  (wb_ovf)
    );

    // State, section counter and downloading edge history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            dl_q  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dl_q  <= downloading;
        end
    end

    // Capture header fields; publish mapper_flags at the last header byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prg_banks    <= '0;
            chr_banks    <= '0;
            flags6       <= '0;
            flags7_hi    <= '0;
            mapper_flags <= '0;
        end else if (hdr_start) begin
            mapper_flags <= '0;
        end else if (hdr_strobe) begin
            case (cnt[3:0])
                4'd4:    prg_banks <= indata;
                4'd5:    chr_banks <= indata;
                4'd6:    flags6    <= indata;
                4'd7:    flags7_hi <= indata[7:4];
                4'd15:   mapper_flags <= build_flags(prg_banks, chr_banks,
                                                     flags6, flags7_hi);
                default: ;
            endcase
        end
    end

    // Next state and counter; sections end only once data is all written.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (downloading) state_n = S_HEADER;
            end
            S_HEADER: begin
                if (!downloading) begin
                    state_n = S_ERROR;
                end else if (indata_clk) begin
                    cnt_n = cnt + 22'd1;
                    if ((cnt < 22'd4) && (indata != magic_byte(cnt[1:0]))) begin
                        state_n = S_ERROR;
                    end else if (cnt == HDR_LAST) begin
                        cnt_n = '0;
                        if (hdr_bad)        state_n = S_ERROR;
                        else if (flags6[2]) state_n = S_TRAINER;
                        else                state_n = S_PRG;
                    end
                end
            end
            S_TRAINER: begin
                if (!downloading) begin
                    state_n = S_ERROR;
                end else if (indata_clk) begin
                    if (cnt == TRAINER_LEN - 22'd1) begin
                        cnt_n   = '0;
                        state_n = S_PRG;
                    end else begin
                        cnt_n = cnt + 22'd1;
                    end
                end
            end
            S_PRG: begin
                if (prg_full) begin
                    if (chr_banks != 8'd0) begin
                        cnt_n   = '0;
                        state_n = S_CHR;
                    end else if (wb_ready) begin
                        state_n = S_DONE;
                    end
                end else if (!downloading) begin
                    state_n = S_ERROR;
                end else if (load) begin
                    cnt_n = cnt + 22'd1;
                    if (wb_ovf) state_n = S_ERROR;
                end
            end
            S_CHR: begin
                if (chr_full) begin
                    if (wb_ready) state_n = S_DONE;
                end else if (!downloading) begin
                    state_n = S_ERROR;
                end else if (load) begin
                    cnt_n = cnt + 22'd1;
                    if (wb_ovf) state_n = S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (dl_rise) begin
                    cnt_n   = '0;
                    state_n = S_HEADER;
                end
            end
            default: state_n = S_ERROR;
        endcase
    end

endmodule

// File: tb/tb_ines_loader.sv
// Scoreboard bench for ines_loader.
// Directed images; expected writes queued, popped on ack.
module tb_ines_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        downloading;
    logic [7:0]  indata;
    logic        indata_clk;
    logic [21:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_write;
    logic        mem_ack;
    logic [31:0] mapper_flags;
    logic        done;
    logic        error;

    logic        ack_en;
    int          total = 0;
    int          bad = 0;
    int          wr_seen = 0;
    logic [29:0] sb[$];
    logic [29:0] mon_exp;

    localparam logic [21:0] CHR_AT = 22'h200000;

    always #5 clk = ~clk;

    assign mem_ack = ack_en & mem_write;

    ines_loader dut (
        .clk          (clk),
        .reset        (reset),
        .downloading  (downloading),
        .indata       (indata),
        .indata_clk   (indata_clk),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_write    (mem_write),
        .mem_ack      (mem_ack),
        .mapper_flags (mapper_flags),
        .done         (done),
        .error        (error)
    );

    function automatic logic [7:0] prg_byte(input int i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic [7:0] chr_byte(input int j);
        return 8'(j) ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every acked write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_write) wr_seen++;
        if (mem_write && mem_ack) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got %h/%h want none",
                         mem_addr, mem_data);
            end else begin
                mon_exp = sb.pop_front();
                if ({mem_addr, mem_data} !== mon_exp) begin
                    bad++;
                    $display("FAIL wr_data: got %h/%h want %h/%h",
                             mem_addr, mem_data, mon_exp[29:8], mon_exp[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        indata     = b;
        indata_clk = 1'b1;
        tick();
        indata_clk = 1'b0;
        tick();
    endtask

    task automatic send_header(input logic [7:0] b3, input logic [7:0] prg,
                               input logic [7:0] chr, input logic [7:0] f6,
                               input logic [7:0] f7);
        strobe(8'h4E);
        strobe(8'h45);
        strobe(8'h53);
        strobe(b3);
        strobe(prg);
        strobe(chr);
        strobe(f6);
        strobe(f7);
        for (int i = 0; i < 8; i++) strobe(8'h00);
    endtask

    task automatic send_prg(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            sb.push_back({22'(i), prg_byte(i)});
            strobe(prg_byte(i));
        end
    endtask

    task automatic send_chr(input int lo, input int hi);
        for (int j = lo; j <= hi; j++) begin
            sb.push_back({CHR_AT + 22'(j), chr_byte(j)});
            strobe(chr_byte(j));
        end
    endtask

    task automatic restart();
        downloading = 1'b0;
        repeat (3) tick();
        downloading = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        reset       = 1'b1;
        downloading = 1'b0;
        indata      = 8'h00;
        indata_clk  = 1'b0;
        ack_en      = 1'b1;
        repeat (3) tick();

        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(mem_data), 32'd0);
        check("rst_write", 32'(mem_write), 32'd0);
        check("rst_flags", mapper_flags, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        tick();

        // A: prg=1 chr=1 mapper 0, zero-wait memory
        downloading = 1'b1;
        repeat (2) tick();
        send_header(8'h1A, 8'd1, 8'd1, 8'h00, 8'h00);
        check("a_flags_hdr", mapper_flags, 32'h0001_0100);
        send_prg(0, 16383);
        send_chr(0, 8190);
        check("a_done_early", 32'(done), 32'd0);
        send_chr(8191, 8191);
        check("a_done", 32'(done), 32'd1);
        check("a_error", 32'(error), 32'd0);
        check("a_flags", mapper_flags, 32'h0001_0100);
        check("a_sb_empty", 32'(sb.size()), 32'd0);
        downloading = 1'b0;
        repeat (3) tick();
        check("a_done_hold", 32'(done), 32'd1);
        check("a_no_err_fall", 32'(error), 32'd0);

        // B: bad magic byte 3
        downloading = 1'b1;
        repeat (3) tick();
        check("b_done_clr", 32'(done), 32'd0);
        wr_seen = 0;
        strobe(8'h4E);
        strobe(8'h45);
        strobe(8'h53);
        check("b_err_before", 32'(error), 32'd0);
        indata     = 8'h1B;
        indata_clk = 1'b1;
        tick();
        check("b_err_next", 32'(error), 32'd1);
        indata_clk = 1'b0;
        tick();
        strobe(8'h01);
        strobe(8'h01);
        check("b_err_sticky", 32'(error), 32'd1);
        check("b_no_write", 32'(wr_seen), 32'd0);
        check("b_flags_clr", mapper_flags, 32'd0);

        // C: memory stalls, second byte overflows
        restart();
        check("c_err_clr", 32'(error), 32'd0);
        ack_en = 1'b0;
        send_header(8'h1A, 8'd1, 8'd0, 8'h00, 8'h00);
        strobe(prg_byte(0));
        check("c_write_held", 32'(mem_write), 32'd1);
        check("c_addr0", 32'(mem_addr), 32'd0);
        strobe(prg_byte(1));
        check("c_ovf_err", 32'(error), 32'd1);
        check("c_ovf_nowr", 32'(mem_write), 32'd0);
        ack_en = 1'b1;

        // D: downloading drops after 100 PRG bytes
        restart();
        check("d_err_clr", 32'(error), 32'd0);
        send_header(8'h1A, 8'd1, 8'd0, 8'h00, 8'h00);
        send_prg(0, 99);
        check("d_err_mid", 32'(error), 32'd0);
        downloading = 1'b0;
        tick();
        check("d_trunc_err", 32'(error), 32'd1);
        check("d_trunc_nowr", 32'(mem_write), 32'd0);
        check("d_sb_empty", 32'(sb.size()), 32'd0);

        // E: recovery with trainer image, CHR-RAM
        downloading = 1'b1;
        repeat (3) tick();
        check("e_err_clr", 32'(error), 32'd0);
        send_header(8'h1A, 8'd1, 8'd0, 8'h14, 8'h10);
        check("e_flags_hdr", mapper_flags, 32'h0800_0111);
        wr_seen = 0;
        for (int i = 0; i < 512; i++) strobe(8'(i) ^ 8'hC0);
        check("e_trainer_nowr", 32'(wr_seen), 32'd0);
        send_prg(0, 0);
        check("e_first_addr", 32'(mem_addr), 32'd0);
        check("e_first_data", 32'(mem_data), 32'h03);
        send_prg(1, 16382);
        check("e_done_early", 32'(done), 32'd0);
        send_prg(16383, 16383);
        check("e_done", 32'(done), 32'd1);
        check("e_error", 32'(error), 32'd0);
        check("e_flags", mapper_flags, 32'h0800_0111);
        check("e_sb_empty", 32'(sb.size()), 32'd0);

        // F: reset in the middle of PRG
        restart();
        send_header(8'h1A, 8'd1, 8'd0, 8'h00, 8'h00);
        send_prg(0, 8);
        ack_en = 1'b0;
        strobe(prg_byte(9));
        check("f_write_pre", 32'(mem_write), 32'd1);
        check("f_addr_pre", 32'(mem_addr), 32'd9);
        check("f_flags_pre", mapper_flags, 32'h0800_0100);
        reset = 1'b1;
        #1;
        check("f_rst_addr", 32'(mem_addr), 32'd0);
        check("f_rst_data", 32'(mem_data), 32'd0);
        check("f_rst_write", 32'(mem_write), 32'd0);
        check("f_rst_flags", mapper_flags, 32'd0);
        check("f_rst_done", 32'(done), 32'd0);
        check("f_rst_error", 32'(error), 32'd0);
        downloading = 1'b0;
        repeat (2) tick();
        reset  = 1'b0;
        ack_en = 1'b1;
        tick();
        downloading = 1'b1;
        repeat (3) tick();
        send_header(8'h1A, 8'd1, 8'd0, 8'h00, 8'h00);
        send_prg(0, 2);
        check("f_addr_after", 32'(mem_addr), 32'd2);
        check("f_err_after", 32'(error), 32'd0);
        check("f_done_after", 32'(done), 32'd0);
        check("f_sb_empty", 32'(sb.size()), 32'd0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ines_loader.md
# ines_loader

Consumes the iNES byte stream produced by the game-data feeder (one byte per `indata_clk` strobe while `downloading` is high) and turns it into cartridge memory writes plus decoded mapper configuration. Validates the 16-byte header, skips an optional 512-byte trainer, and writes PRG then CHR bytes through a single-entry write buffer with a ready/ack handshake. Sits between the ROM source and the SDRAM/BRAM memory arbiter; `mapper_flags` and `done` drive mapper and CPU/PPU reset release.

## Interface
- `CHR_BASE`, 22'h200000: byte address of CHR data in cartridge memory; PRG starts at 0.
- `MAX_PRG_BANKS`, 128: largest legal PRG size in 16 KB units.

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `downloading`  in  1  high for the whole transfer
- `indata`  in  8  stream byte, valid with `indata_clk`
- `indata_clk`  in  1  one-cycle strobe; upstream guarantees ≥1 idle cycle between strobes
- `mem_addr`  out  22  write byte address
- `mem_data`  out  8  write data
- `mem_write`  out  1  write request, held until acked
- `mem_ack`  in  1  memory accepted the current write this cycle
- `mapper_flags`  out  32  decoded configuration, valid when `done`
- `done`  out  1  image fully written
- `error`  out  1  bad header, truncation or overflow; sticky

## Operation
- States: IDLE, HEADER, TRAINER, PRG, CHR, DONE, ERROR.
- IDLE: all counters cleared, `done`=`error`=0; go HEADER when `downloading`=1.
- HEADER: byte index 0–15. Bytes 0–3 must equal 4E 45 53 1A, else ERROR. Byte 4 = prg_banks (0 or >`MAX_PRG_BANKS` → ERROR at index 15). Byte 5 = chr_banks. Byte 6 = flags6, byte 7 = flags7; bytes 8–15 ignored. After index 15: TRAINER if flags6[2], else PRG.
- TRAINER: discard 512 bytes, then PRG.
- PRG: write prg_banks×16384 bytes at addresses 0 upward. Then CHR if chr_banks≠0, else DONE.
- CHR: write chr_banks×8192 bytes at `CHR_BASE` upward. Then DONE.
- Transition to DONE happens only after the last write is acked.
- DONE: `done`=1; further strobes ignored; `downloading` falling then rising restarts at HEADER with `done` cleared.
- ERROR: `error`=1, `mem_write`=0; left only by `downloading` rising edge (restart) or reset.
- Truncation: `downloading` falls in HEADER/TRAINER/PRG/CHR → ERROR.
- Write buffer: one entry. Strobe in PRG/CHR loads addr/data and sets `mem_write`. `mem_ack` with `mem_write` empties it. Strobe while full and no ack that cycle → ERROR (overflow). Strobe together with ack: new byte replaces old, `mem_write` stays 1.
- mapper_flags: [7:0] = {flags7[7:4], flags6[7:4]}, [15:8] prg_banks, [23:16] chr_banks, [24] flags6[0] mirroring, [25] flags6[1] battery, [26] flags6[3] four-screen, [27] chr_banks==0 (CHR-RAM), [31:28] 0. Latched at header index 15; held until restart.
- Section byte counter 22 bits, compared against the size computed from bank count (shift, no multiplier).

## Timing
- Reset: state IDLE; `mem_addr`=0, `mem_data`=0, `mem_write`=0, `mapper_flags`=0, `done`=0, `error`=0.
- Strobe at cycle t → `mem_write`, `mem_addr`, `mem_data` registered at t+1.
- Header check error → `error`=1 at t+1 after offending byte.
- Last byte acked at cycle a → `done`=1 at a+1.
- Zero-wait memory (ack same cycle as `mem_write`) sustains the full strobe rate.

## Structure
- Package `ines_pkg`: state enum, magic bytes, PRG/CHR bank-size shifts, trainer length, `mapper_flags` bit-position constants.
- Sub-module `ines_wr_buffer`: single-entry addr/data holding register with ready/ack and overflow flag.

## Test plan
- Valid image, prg=1, chr=1, mapper 0, zero-wait ack → 16384 writes at 0..3FFF, 8192 at 200000..201FFF, `done`=1, `mapper_flags`=0x0001_0100.
- Header byte 3 = 0x1B → `error`=1 the cycle after byte 3, no `mem_write` ever.
- flags6=0x14, flags7=0x10, chr=0 → trainer 512 bytes skipped, first write at addr 0 is byte 528, `mapper_flags`[7:0]=0x11, [27]=1, `done` after PRG.
- Ack stalled 3 cycles with strobes every 2 cycles → overflow, `error`=1, `mem_write`=0.
- `downloading` drops after 100 PRG bytes → ERROR; re-raise with valid image → `error` clears, full load completes.
- Reset asserted mid-PRG → all outputs zero immediately, next `downloading` restarts at HEADER.
